taus_urng_bank: RTL and testbench

//  Parametrised bank of NUM_CH independent taus88 Tausworthe uniform RNGs (3x32-bit

---
 rtl/taus_urng_bank_if.sv | 24 ++
 rtl/taus_urng_bank.sv | 118 +++++++++++
 tb/tb_taus_urng_bank.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/taus_urng_bank_if.sv
// Control and data bundle for the Tausworthe RNG bank: advance enable, seed
// write port, per-channel outputs and status flags.
interface taus_urng_bank_if #(
  parameter int NUM_CH = 2
);
  logic                  iEn;
  logic                  iSeed_wr;
  logic [3:0]            iSeed_ch;
  logic [1:0]            iSeed_sel;
  logic [31:0]           iSeed_data;
  logic [32*NUM_CH-1:0]  oTaus;
  logic                  oValid;
  logic                  oSeed_err;

  modport master (
    output iEn, iSeed_wr, iSeed_ch, iSeed_sel, iSeed_data,
    input  oTaus, oValid, oSeed_err
  );

  modport slave (
    input  iEn, iSeed_wr, iSeed_ch, iSeed_sel, iSeed_data,
    output oTaus, oValid, oSeed_err
  );
endinterface

// File: rtl/taus_urng_bank.sv
// Bank of NUM_CH independent taus88 uniform generators with runtime seed
// loading, seed sanitisation and a warm-up phase that gates oValid.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_WARM | discarding enabled steps until warm_cnt reaches zero
// ST_RUN  | outputs are post-warm-up, oValid asserted
module taus_urng_bank #(
  parameter int          NUM_CH       = 2,
  parameter int          WARMUP_CYC   = 16,
  parameter logic [31:0] DEFAULT_SEED = 32'd12345
) (
  input  logic            iClk,
  input  logic            iRst,
  taus_urng_bank_if.slave bus
);

  localparam int CNT_W = (WARMUP_CYC > 0) ? $clog2(WARMUP_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP_CYC);

  typedef enum logic {ST_WARM, ST_RUN} state_e;

  // Smallest legal value per component; lower seeds would lock the LFSR
  // into a degenerate sequence.
  function automatic logic [31:0] comp_min(input int k);
    case (k)
      0:       return 32'd2;
      1:       return 32'd8;
      default: return 32'd16;
    endcase
  endfunction

  function automatic logic [31:0] sanitise(input logic [31:0] v, input int k);
    return (v < comp_min(k)) ? comp_min(k) : v;
  endfunction

  function automatic logic [31:0] step_comp(input logic [31:0] s, input int k);
    case (k)
      0:       return ((s & 32'hFFFFFFFE) << 12) ^ (((s << 13) ^ s) >> 19);
      1:       return ((s & 32'hFFFFFFF8) << 4)  ^ (((s << 2)  ^ s) >> 25);
      default: return ((s & 32'hFFFFFFF0) << 17) ^ (((s << 3)  ^ s) >> 11);
    endcase
  endfunction

  logic [31:0]          s_q [NUM_CH][3];
  logic [31:0]          s_d [NUM_CH][3];
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     warm_cnt_q, warm_cnt_d;
  logic                 seed_err_q, seed_err_d;
  logic                 valid_wr;
  logic [32*NUM_CH-1:0] taus;

  // Decode the seed write and compute per-component next state; a valid
  // write freezes every component of the target channel for that cycle.
  always_comb begin
    valid_wr   = bus.iSeed_wr && ({1'b0, bus.iSeed_ch} < 5'(NUM_CH)) &&
                 (bus.iSeed_sel != 2'd3);
    seed_err_d = bus.iSeed_wr && !valid_wr;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < 3; k++) begin
        s_d[c][k] = s_q[c][k];
        if (valid_wr && (bus.iSeed_ch == 4'(c))) begin
          if (bus.iSeed_sel == 2'(k)) s_d[c][k] = sanitise(bus.iSeed_data, k);
        end else if (bus.iEn) begin
          s_d[c][k] = step_comp(s_q[c][k], k);
        end
      end
    end
  end

  // Warm-up FSM: valid writes restart warm-up, enabled steps count it down.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    if (valid_wr) begin
      state_d    = ST_WARM;
      warm_cnt_d = CNT_INIT;
    end else if (state_q == ST_WARM) begin
      if (warm_cnt_q == '0) begin
        state_d = ST_RUN;
      end else if (bus.iEn) begin
        warm_cnt_d = warm_cnt_q - CNT_W'(1);
      end
    end
  end

  // State registers; reset reloads the sanitised default seeds.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < 3; k++) begin
          s_q[c][k] <= sanitise(DEFAULT_SEED + 32'(3 * c + k), k);
        end
      end
      state_q    <= ST_WARM;
      warm_cnt_q <= CNT_INIT;
      seed_err_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      seed_err_q <= seed_err_d;
    end
  end

  // Channel outputs straight from the state registers.
  always_comb begin
    taus = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      taus[32*c +: 32] = s_q[c][0] ^ s_q[c][1] ^ s_q[c][2];
    end
  end

  assign bus.oTaus     = taus;
  assign bus.oValid    = (state_q == ST_RUN);
  assign bus.oSeed_err = seed_err_q;

endmodule

// File: tb/tb_taus_urng_bank.sv
// Directed bench for taus_urng_bank: a 3-channel bank with a 4-step warm-up
// and a twin with no warm-up, both driven by the same stimulus.
module tb_taus_urng_bank;

  localparam int NCH = 3;

  logic iClk = 1'b0;
  logic iRst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 iClk = ~iClk;

  taus_urng_bank_if #(.NUM_CH(NCH)) bus ();
  taus_urng_bank_if #(.NUM_CH(NCH)) bus0 ();

  assign bus0.iEn        = bus.iEn;
  assign bus0.iSeed_wr   = bus.iSeed_wr;
  assign bus0.iSeed_ch   = bus.iSeed_ch;
  assign bus0.iSeed_sel  = bus.iSeed_sel;
  assign bus0.iSeed_data = bus.iSeed_data;

  taus_urng_bank #(.NUM_CH(NCH), .WARMUP_CYC(4), .DEFAULT_SEED(32'd12345)) u_dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  taus_urng_bank #(.NUM_CH(NCH), .WARMUP_CYC(0), .DEFAULT_SEED(32'd12345)) u_dut0 (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus0)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        wr;
    logic [3:0]  ch;
    logic [1:0]  sel;
    logic [31:0] data;
    logic        ct;
    logic [31:0] t0, t1, t2;
    logic        v, v0, err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic en, input logic wr,
                              input logic [3:0] ch, input logic [1:0] sel,
                              input logic [31:0] data, input logic ct,
                              input logic [31:0] t0, input logic [31:0] t1,
                              input logic [31:0] t2, input logic v,
                              input logic v0, input logic err);
    vec_t r;
    r.rst = rst; r.en = en; r.wr = wr; r.ch = ch; r.sel = sel; r.data = data;
    r.ct = ct; r.t0 = t0; r.t1 = t1; r.t2 = t2; r.v = v; r.v0 = v0; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic wr,
                       input logic [3:0] ch, input logic [1:0] sel,
                       input logic [31:0] data);
    iRst           = rst;
    bus.iEn        = en;
    bus.iSeed_wr   = wr;
    bus.iSeed_ch   = ch;
    bus.iSeed_sel  = sel;
    bus.iSeed_data = data;
  endtask

  localparam logic [31:0] R0 = 32'h0000_3038;
  localparam logic [31:0] R1 = 32'h0000_303F;
  localparam logic [31:0] R2 = 32'h0000_303E;
  localparam logic [31:0] A1 = 32'h0020_2080;
  localparam logic [31:0] A2 = 32'h0200_2C80;
  localparam logic [31:0] A3 = 32'h4808_8062;
  localparam logic [31:0] A4 = 32'h804D_2000;
  localparam logic [31:0] A5 = 32'h4280_49A0;

  initial begin
    int n;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 32'd0);
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_t0", -1, bus.oTaus[31:0],  R0);
    chk("rst_t1", -1, bus.oTaus[63:32], R1);
    chk("rst_t2", -1, bus.oTaus[95:64], R2);
    chk("rst_valid", -1, 32'(bus.oValid), 32'd0);
    chk("rst_err", -1, 32'(bus.oSeed_err), 32'd0);
    chk("rst_valid0", -1, 32'(bus0.oValid), 32'd0);

    //                rst   en    wr    ch     sel   data           ct    t0          t1          t2          v     v0    err
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 32'd0,         1'b1, R0,         R1,         R2,         1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b1, R0,         R1,         R2,         1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 32'd0,         1'b1, R0,         R1,         R2,         1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'd0, 2'd0, 32'd0,         1'b1, 32'h3,      R1,         R2,         1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'd0, 2'd1, 32'd3,         1'b1, 32'h3031,   R1,         R2,         1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'd0, 2'd2, 32'd15,        1'b1, 32'h1A,     R1,         R2,         1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'd1, 2'd0, 32'd2,         1'b1, 32'h1A,     32'h1,      R2,         1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'd1, 2'd1, 32'd8,         1'b1, 32'h1A,     32'h3034,   R2,         1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'd1, 2'd2, 32'd16,        1'b1, 32'h1A,     32'h1A,     R2,         1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'd2, 2'd0, 32'd1,         1'b1, 32'h1A,     32'h1A,     32'h3,      1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'd2, 2'd1, 32'd7,         1'b1, 32'h1A,     32'h1A,     32'h304B,   1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'd2, 2'd2, 32'd0,         1'b1, 32'h1A,     32'h1A,     32'h1A,     1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b1, A1,         A1,         A1,         1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 32'd0,         1'b1, A1,         A1,         A1,         1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b1, A2,         A2,         A2,         1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'd5, 2'd0, 32'h1234,      1'b1, A2,         A2,         A2,         1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'd3, 2'd1, 32'h1234,      1'b1, A2,         A2,         A2,         1'b0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 32'd0,         1'b1, A2,         A2,         A2,         1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b1, A3,         A3,         A3,         1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b1, A4,         A4,         A4,         1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 32'd0,         1'b1, A4,         A4,         A4,         1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 4'd1, 2'd3, 32'd0,         1'b1, A4,         A4,         A4,         1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 4'd1, 2'd1, 32'd8,         1'b1, A5,         32'h80452008, A5,       1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b0, 32'd0,      32'd0,      32'd0,      1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b0, 32'd0,      32'd0,      32'd0,      1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b0, 32'd0,      32'd0,      32'd0,      1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b0, 32'd0,      32'd0,      32'd0,      1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 32'd0,         1'b0, 32'd0,      32'd0,      32'd0,      1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b0, 32'd0,      32'd0,      32'd0,      1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b1, R0,         R1,         R2,         1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b0, 32'd0,      32'd0,      32'd0,      1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b0, 32'd0,      32'd0,      32'd0,      1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 32'd0,         1'b1, R0,         R1,         R2,         1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b0, 32'd0,      32'd0,      32'd0,      1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b0, 32'd0,      32'd0,      32'd0,      1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b0, 32'd0,      32'd0,      32'd0,      1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0,         1'b0, 32'd0,      32'd0,      32'd0,      1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 32'd0,         1'b0, 32'd0,      32'd0,      32'd0,      1'b1, 1'b1, 1'b0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].wr, vecs[i].ch, vecs[i].sel, vecs[i].data);
      @(posedge iClk);
      #1;
      if (vecs[i].ct) begin
        chk("taus_ch0", i, bus.oTaus[31:0],  vecs[i].t0);
        chk("taus_ch1", i, bus.oTaus[63:32], vecs[i].t1);
        chk("taus_ch2", i, bus.oTaus[95:64], vecs[i].t2);
      end
      chk("valid", i, 32'(bus.oValid), 32'(vecs[i].v));
      chk("valid_nowarm", i, 32'(bus0.oValid), 32'(vecs[i].v0));
      chk("seed_err", i, 32'(bus.oSeed_err), 32'(vecs[i].err));
    end

    // Fresh write while running, then continuous stepping: oValid must come
    // back on the cycle after the fourth enabled step, i.e. 5 cycles later.
    drive(1'b1, 1'b0, 1'b1, 4'd0, 2'd0, 32'd5);
    @(posedge iClk);
    #1;
    chk("wr_drops_valid", 100, 32'(bus.oValid), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 4'd0, 2'd0, 32'd0);
    n = 0;
    while (n < 20 && !bus.oValid) begin
      @(posedge iClk);
      #1;
      n++;
    end
    chk("warmup_cycles", 101, 32'(n), 32'd5);

    // A single rejected write gives a pulse of exactly one cycle.
    drive(1'b1, 1'b0, 1'b1, 4'd15, 2'd2, 32'd0);
    @(posedge iClk);
    #1;
    chk("err_pulse", 102, 32'(bus.oSeed_err), 32'd1);
    chk("err_keeps_valid", 102, 32'(bus.oValid), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 2'd0, 32'd0);
    @(posedge iClk);
    #1;
    chk("err_clears", 103, 32'(bus.oSeed_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
